ber_checker: RTL and testbench

BER_CHECKER -- requirements
Module: ber_checker

---
 rtl/ber_pkg.sv | 14 +
 rtl/ber_checker_if.sv | 29 ++
 rtl/ref_delay_line.sv | 32 +++
 rtl/ber_checker.sv | 118 +++++++++++
 tb/tb_ber_checker.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ber_pkg.sv
// Shared types and default sizing for the PRBS bit-error-rate checker.
// State encoding and parameter defaults live here so all files agree.
package ber_pkg;

  localparam int NB_DELAY_DEF   = 9;
  localparam int NB_COUNT_DEF   = 64;
  localparam int SEARCH_LEN_DEF = 511;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/ber_checker_if.sv
// Signal bundle around the BER checker: symbol stream in, lock and counts out.
// master drives the stream, slave is the checker's view.
interface ber_checker_if
  import ber_pkg::*;
#(
  parameter int NB_DELAY = NB_DELAY_DEF,
  parameter int NB_COUNT = NB_COUNT_DEF
) ();

  logic                enable;
  logic                ref_bit;
  logic                rx_bit;
  logic                clear;
  logic                locked;
  logic [NB_DELAY-1:0] latency;
  logic [NB_COUNT-1:0] bit_count;
  logic [NB_COUNT-1:0] err_count;

  modport master (
    output enable, ref_bit, rx_bit, clear,
    input  locked, latency, bit_count, err_count
  );

  modport slave (
    input  enable, ref_bit, rx_bit, clear,
    output locked, latency, bit_count, err_count
  );

endinterface

// File: rtl/ref_delay_line.sv
// Reference delay line: tap 0 is the live bit, tap k the bit k strobes ago.
// Shifts only on enabled symbols.
module ref_delay_line
  import ber_pkg::*;
#(
  parameter int NB_DELAY = NB_DELAY_DEF
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_bit,
  input  logic [NB_DELAY-1:0] i_sel,
  output logic                o_bit
);

  localparam int DEPTH = 2 ** NB_DELAY;

  logic [DEPTH-1:1] del_q;
  logic [DEPTH-1:0] taps;

  assign taps  = {del_q, i_bit};
  assign o_bit = taps[i_sel];

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      del_q <= '0;
    end else if (i_enable) begin
      del_q <= taps[DEPTH-2:0];
    end
  end

endmodule

// File: rtl/ber_checker.sv
// PRBS BER checker: sweeps reference delays until one matches a full
// window error-free, then counts symbols and errors at that delay.
module ber_checker
  import ber_pkg::*;
#(
  parameter int NB_DELAY   = NB_DELAY_DEF,
  parameter int NB_COUNT   = NB_COUNT_DEF,
  parameter int SEARCH_LEN = SEARCH_LEN_DEF
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_ref_bit,
  input  logic                i_rx_bit,
  input  logic                i_clear,
  output logic                o_locked,
  output logic [NB_DELAY-1:0] o_latency,
  output logic [NB_COUNT-1:0] o_bit_count,
  output logic [NB_COUNT-1:0] o_err_count
);

  localparam int NB_SYM = $clog2(SEARCH_LEN + 1);
  localparam logic [NB_SYM-1:0] LAST_SYM =
    NB_SYM'(SEARCH_LEN - 1);

  state_e              state_q, state_d;
  logic [NB_DELAY-1:0] cand_q, cand_d;
  logic [NB_DELAY-1:0] lat_q, lat_d;
  logic [NB_SYM-1:0]   sym_q, sym_d;
  logic [NB_SYM-1:0]   cerr_q, cerr_d;
  logic [NB_COUNT-1:0] bit_q, bit_d;
  logic [NB_COUNT-1:0] err_q, err_d;

  logic [NB_DELAY-1:0] sel;
  logic                ref_sel;
  logic                miss;

  assign sel  = (state_q == LOCKED) ? lat_q : cand_q;
  assign miss = i_rx_bit ^ ref_sel;

  ref_delay_line #(
    .NB_DELAY (NB_DELAY)
  ) u_delay (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_bit    (i_ref_bit),
    .i_sel    (sel),
    .o_bit    (ref_sel)
  );

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    lat_d   = lat_q;
    sym_d   = sym_q;
    cerr_d  = cerr_q;
    bit_d   = bit_q;
    err_d   = err_q;
    // clear beats a coincident symbol; latency is kept
    if (i_clear) begin
      state_d = SEARCH;
      cand_d  = '0;
      sym_d   = '0;
      cerr_d  = '0;
      bit_d   = '0;
      err_d   = '0;
    end else if (i_enable) begin
      unique case (state_q)
        SEARCH: begin
          if (sym_q == LAST_SYM) begin
            sym_d  = '0;
            cerr_d = '0;
            if (cerr_q == '0 && !miss) begin
              state_d = LOCKED;
              lat_d   = cand_q;
            end else begin
              cand_d = cand_q + NB_DELAY'(1);
            end
          end else begin
            sym_d  = sym_q + NB_SYM'(1);
            cerr_d = cerr_q + NB_SYM'(miss);
          end
        end
        LOCKED: begin
          if (~&bit_q) bit_d = bit_q + NB_COUNT'(1);
          if (miss && ~&err_q) err_d = err_q + NB_COUNT'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= SEARCH;
      cand_q  <= '0;
      lat_q   <= '0;
      sym_q   <= '0;
      cerr_q  <= '0;
      bit_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      lat_q   <= lat_d;
      sym_q   <= sym_d;
      cerr_q  <= cerr_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
    end
  end

  assign o_locked    = (state_q == LOCKED);
  assign o_latency   = lat_q;
  assign o_bit_count = bit_q;
  assign o_err_count = err_q;

endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker: PRBS9 stream delayed 37 symbols, scoreboarded
// per symbol, plus a narrow-counter and a random-rx instance.
module tb_ber_checker;

  localparam int L      = 31;
  localparam int D      = 37;
  localparam int LOCK_N = (D + 1) * L;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_n;

  ber_checker_if #(.NB_DELAY(9), .NB_COUNT(64)) ifc ();

  ber_checker #(
    .NB_DELAY(9), .NB_COUNT(64), .SEARCH_LEN(L)
  ) u_dut (
    .clock       (clock),
    .i_reset     (rst_n),
    .i_enable    (ifc.enable),
    .i_ref_bit   (ifc.ref_bit),
    .i_rx_bit    (ifc.rx_bit),
    .i_clear     (ifc.clear),
    .o_locked    (ifc.locked),
    .o_latency   (ifc.latency),
    .o_bit_count (ifc.bit_count),
    .o_err_count (ifc.err_count)
  );

  logic       b_rx, b_locked;
  logic [8:0] b_lat;
  logic [7:0] b_bc, b_ec;

  ber_checker #(
    .NB_DELAY(9), .NB_COUNT(8), .SEARCH_LEN(L)
  ) u_b (
    .clock       (clock),
    .i_reset     (rst_n),
    .i_enable    (ifc.enable),
    .i_ref_bit   (ifc.ref_bit),
    .i_rx_bit    (b_rx),
    .i_clear     (1'b0),
    .o_locked    (b_locked),
    .o_latency   (b_lat),
    .o_bit_count (b_bc),
    .o_err_count (b_ec)
  );

  logic        c_en, c_ref, c_rx, c_locked;
  logic [8:0]  c_lat;
  logic [63:0] c_bc, c_ec;

  ber_checker #(
    .NB_DELAY(9), .NB_COUNT(64), .SEARCH_LEN(L)
  ) u_c (
    .clock       (clock),
    .i_reset     (rst_n),
    .i_enable    (c_en),
    .i_ref_bit   (c_ref),
    .i_rx_bit    (c_rx),
    .i_clear     (1'b0),
    .o_locked    (c_locked),
    .o_latency   (c_lat),
    .o_bit_count (c_bc),
    .o_err_count (c_ec)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        lk;
    logic [8:0]  lat;
    logic [63:0] bc;
    logic [63:0] ec;
  } exp_t;

  exp_t exp_q[$];

  logic [8:0]  lfsr;
  bit          hist [1024];
  int          n_sym;
  bit          b_inv;
  logic        m_lk;
  logic [8:0]  m_lat;
  logic [63:0] m_bc, m_ec;
  int          m_n;
  bit          c_done;

  task automatic compare_one(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_locked"}, 64'(ifc.locked), 64'(e.lk));
      chk({tag, "_latency"}, 64'(ifc.latency), 64'(e.lat));
      chk({tag, "_bits"}, ifc.bit_count, e.bc);
      chk({tag, "_errs"}, ifc.err_count, e.ec);
    end
  endtask

  // one symbol slot: strobe cycle then three idle cycles
  task automatic send(input bit en, input bit clr, input bit flip);
    bit   rb, ra;
    exp_t e;
    rb = 1'b0;
    ra = 1'b0;
    @(negedge clock);
    if (en) begin
      rb = lfsr[8];
      hist[n_sym % 1024] = rb;
      if (n_sym >= D) ra = hist[(n_sym - D) % 1024];
      lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
      n_sym++;
    end
    ifc.enable  = en;
    ifc.clear   = clr;
    ifc.ref_bit = rb;
    ifc.rx_bit  = ra ^ flip;
    b_rx        = ra ^ b_inv;
    if (clr) begin
      m_lk = 1'b0;
      m_bc = '0;
      m_ec = '0;
      m_n  = 0;
    end else if (en) begin
      if (m_lk) begin
        if (m_bc != '1) m_bc++;
        if (flip && m_ec != '1) m_ec++;
      end else begin
        m_n++;
        if (m_n == LOCK_N) begin
          m_lk  = 1'b1;
          m_lat = 9'(D);
        end
      end
    end
    e = '{m_lk, m_lat, m_bc, m_ec};
    exp_q.push_back(e);
    exp_q.push_back(e);
    @(negedge clock);
    ifc.enable = 1'b0;
    ifc.clear  = 1'b0;
    compare_one("slot");
    @(negedge clock);
    @(negedge clock);
    compare_one("idle");
  endtask

  initial begin
    bit ever;
    c_en   = 1'b0;
    c_ref  = 1'b0;
    c_rx   = 1'b0;
    c_done = 1'b0;
    ever   = 1'b0;
    @(posedge rst_n);
    for (int i = 0; i < 2 * 512 * L; i++) begin
      @(negedge clock);
      if (c_locked) ever = 1'b1;
      c_en  = 1'b1;
      c_ref = 1'($urandom);
      c_rx  = 1'($urandom);
    end
    @(negedge clock);
    c_en = 1'b0;
    if (c_locked) ever = 1'b1;
    chk("rand_nolock", 64'(ever), 64'd0);
    chk("rand_bits", c_bc, 64'd0);
    chk("rand_errs", c_ec, 64'd0);
    chk("rand_latency", 64'(c_lat), 64'd0);
    c_done = 1'b1;
  end

  initial begin
    rst_n       = 1'b0;
    ifc.enable  = 1'b0;
    ifc.clear   = 1'b0;
    ifc.ref_bit = 1'b0;
    ifc.rx_bit  = 1'b0;
    b_rx        = 1'b0;
    b_inv       = 1'b0;
    lfsr        = 9'h1FF;
    n_sym       = 0;
    m_lk        = 1'b0;
    m_lat       = '0;
    m_bc        = '0;
    m_ec        = '0;
    m_n         = 0;

    #3;
    chk("rst_locked", 64'(ifc.locked), 64'd0);
    chk("rst_latency", 64'(ifc.latency), 64'd0);
    chk("rst_bits", ifc.bit_count, 64'd0);
    chk("rst_errs", ifc.err_count, 64'd0);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;

    for (int i = 0; i < LOCK_N; i++) send(1'b1, 1'b0, 1'b0);
    chk("lock_latency", 64'(ifc.latency), 64'd37);
    chk("b_locked", 64'(b_locked), 64'd1);
    chk("b_latency", 64'(b_lat), 64'd37);

    b_inv = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (i == 253) chk("b_bits_254", 64'(b_bc), 64'd254);
      if (i == 254 || i == 299) begin
        chk("b_bits_sat", 64'(b_bc), 64'd255);
        chk("b_errs_sat", 64'(b_ec), 64'd255);
        chk("b_still_locked", 64'(b_locked), 64'd1);
      end
    end
    chk("run_bits", ifc.bit_count, 64'd10000);
    chk("run_errs", ifc.err_count, 64'd0);

    for (int i = 0; i < 1000; i++)
      send(1'b1, 1'b0, (i == 100 || i == 500 || i == 900));
    chk("flip_bits", ifc.bit_count, 64'd11000);
    chk("flip_errs", ifc.err_count, 64'd3);
    chk("flip_locked", 64'(ifc.locked), 64'd1);

    send(1'b1, 1'b1, 1'b0);
    chk("clr_bits", ifc.bit_count, 64'd0);
    chk("clr_locked", 64'(ifc.locked), 64'd0);
    for (int i = 0; i < LOCK_N; i++) send(1'b1, 1'b0, 1'b0);
    chk("relock_latency", 64'(ifc.latency), 64'd37);
    chk("relock_locked", 64'(ifc.locked), 64'd1);

    send(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20 * L + 5; i++) send(1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked", 64'(ifc.locked), 64'd0);
    chk("arst_latency", 64'(ifc.latency), 64'd0);
    chk("arst_bits", ifc.bit_count, 64'd0);
    chk("arst_errs", ifc.err_count, 64'd0);
    m_lk  = 1'b0;
    m_lat = '0;
    m_bc  = '0;
    m_ec  = '0;
    m_n   = 0;
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < LOCK_N; i++) send(1'b1, 1'b0, 1'b0);
    chk("rst_relock_latency", 64'(ifc.latency), 64'd37);

    for (int i = 0; i < 40000 && !c_done; i++) @(negedge clock);
    chk("rand_done", 64'(c_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
